// File: rtl/output_port_scheduler.sv
// Wormhole output-port arbiter: round-robin grant among ingress buffers, per-VC credit
// tracking, and a watchdog that frees a port whose owner stops sending mid-packet.
module output_port_scheduler #(
    parameter int NUM_IN      = 8,
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int TIMEOUT     = 64,
    localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CW  = $clog2(BUFFER_SIZE + 1),
    localparam int IW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             req,
    input  logic [NUM_IN-1:0][VCW-1:0]    req_vc,
    input  logic [NUM_IN-1:0]             req_tail,
    input  logic                          flit_sent,
    input  logic [NUM_VCS-1:0]            credit_granted,
    output logic [NUM_IN-1:0]             grant,
    output logic                          issue,
    output logic [VCW-1:0]                issue_vc,
    output logic [NUM_VCS-1:0][CW-1:0]    credits,
    output logic                          err_timeout,
    output logic                          err_credit
);

    typedef enum logic [1:0] {IDLE, LOCKED, WAIT_ACK} state_t;

    state_t                       state_q, state_d;
    logic [NUM_IN-1:0]            grant_q, grant_d;
    logic [IW-1:0]                owner_q, owner_d;
    logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
    logic                         tail_q, tail_d;
    logic [WW-1:0]                wd_q, wd_d;
    logic [NUM_VCS-1:0][CW-1:0]   credits_q, credits_d;
    logic                         err_credit_q, credit_overflow;

    logic [NUM_IN-1:0]            eligible;
    logic                         pick_found;
    logic [IW-1:0]                pick_idx;
    logic [VCW-1:0]               owner_vc;
    logic [IW-1:0]                next_owner;
    logic                         timeout_hit;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = req[i] && (credits_q[req_vc[i]] != '0);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping past the top index.
    always_comb begin
        int idx;
        logic [IW-1:0] idx_v;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            idx_v = IW'(idx);
            if (!pick_found && eligible[idx_v]) begin
                pick_found = 1'b1;
                pick_idx   = idx_v;
            end
        end
    end

    assign owner_vc    = req_vc[owner_q];
    assign next_owner  = (owner_q == IW'(NUM_IN - 1)) ? '0 : owner_q + 1'b1;
    assign issue       = (state_q == LOCKED) && !rst && req[owner_q] && (credits_q[owner_vc] != '0);
    assign issue_vc    = (state_q == LOCKED) ? owner_vc : '0;
    assign timeout_hit = (state_q == LOCKED) && !rst && !issue && (wd_q == WW'(TIMEOUT - 1));
    assign err_timeout = timeout_hit;
    assign grant       = grant_q;
    assign credits     = credits_q;
    assign err_credit  = err_credit_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        tail_d   = tail_q;
        wd_d     = '0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = NUM_IN'(1) << pick_idx;
                    owner_d = pick_idx;
                end
            end
            LOCKED: begin
                if (issue) begin
                    tail_d  = req_tail[owner_q];
                    state_d = WAIT_ACK;
                end else if (timeout_hit) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_owner;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (flit_sent) begin
                    if (tail_q) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_owner;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // A return and an issue on the same VC cancel; a return at full count is a protocol error.
    always_comb begin
        credits_d       = credits_q;
        credit_overflow = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (issue && (issue_vc == VCW'(v))) begin
                if (!credit_granted[v]) begin
                    credits_d[v] = credits_q[v] - 1'b1;
                end
            end else if (credit_granted[v]) begin
                if (credits_q[v] == CW'(BUFFER_SIZE)) begin
                    credit_overflow = 1'b1;
                end else begin
                    credits_d[v] = credits_q[v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            tail_q       <= 1'b0;
            wd_q         <= '0;
            err_credit_q <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credits_q[v] <= CW'(BUFFER_SIZE);
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            tail_q       <= tail_d;
            wd_q         <= wd_d;
            credits_q    <= credits_d;
            err_credit_q <= err_credit_q | credit_overflow;
        end
    end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: a table of per-cycle vectors for arbitration,
// wormhole hold and reset, plus hand sequences for credits, credit errors and the watchdog.
module tb_output_port_scheduler;

    logic            clk;
    logic            rst;
    logic [7:0]      req;
    logic [7:0][0:0] req_vc;
    logic [7:0]      req_tail;
    logic            flit_sent;
    logic [1:0]      credit_granted;
    logic [7:0]      grant;
    logic            issue;
    logic [0:0]      issue_vc;
    logic [1:0][3:0] credits;
    logic            err_timeout;
    logic            err_credit;

    int total_checks;
    int bad_checks;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] vc;
        logic [7:0] tail;
        logic       flit;
        logic [1:0] cg;
        logic [7:0] e_grant;
        logic       e_issue;
        logic [3:0] e_c0;
        logic [3:0] e_c1;
    } vec_t;

    vec_t tbl[$];

    output_port_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_vc         (req_vc),
        .req_tail       (req_tail),
        .flit_sent      (flit_sent),
        .credit_granted (credit_granted),
        .grant          (grant),
        .issue          (issue),
        .issue_vc       (issue_vc),
        .credits        (credits),
        .err_timeout    (err_timeout),
        .err_credit     (err_credit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global time limit reached");
        $fatal(1, "[TB] time limit");
    end

    function automatic vec_t mkVec(input logic r, input logic [7:0] rq, input logic [7:0] vc,
                                   input logic [7:0] tl, input logic fs, input logic [1:0] cg,
                                   input logic [7:0] g, input logic iss, input logic [3:0] c0,
                                   input logic [3:0] c1);
        vec_t t;
        t.rst = r; t.req = rq; t.vc = vc; t.tail = tl; t.flit = fs; t.cg = cg;
        t.e_grant = g; t.e_issue = iss; t.e_c0 = c0; t.e_c1 = c1;
        return t;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic [7:0] vc,
                                 input logic [7:0] tl, input logic fs, input logic [1:0] cg);
        @(negedge clk);
        rst            = r;
        req            = rq;
        req_vc         = vc;
        req_tail       = tl;
        flit_sent      = fs;
        credit_granted = cg;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        logic [3:0] exp_c;
        total_checks   = 0;
        bad_checks     = 0;
        rst            = 1'b1;
        req            = '0;
        req_vc         = '0;
        req_tail       = '0;
        flit_sent      = 1'b0;
        credit_granted = '0;

        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
        checkOutput("reset_grant", 32'(grant), 32'h0);
        checkOutput("reset_issue", 32'(issue), 32'h0);
        checkOutput("reset_issue_vc", 32'(issue_vc), 32'h0);
        checkOutput("reset_c0", 32'(credits[0]), 32'd8);
        checkOutput("reset_c1", 32'(credits[1]), 32'd8);
        checkOutput("reset_err_timeout", 32'(err_timeout), 32'h0);
        checkOutput("reset_err_credit", 32'(err_credit), 32'h0);

        // Round robin between requesters 0 and 2 with single-flit packets
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 0, 2'b00, 8'h00, 0, 8, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 0, 2'b00, 8'h01, 1, 8, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 1, 2'b00, 8'h01, 0, 7, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 0, 2'b00, 8'h00, 0, 7, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 0, 2'b00, 8'h04, 1, 7, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 1, 2'b00, 8'h04, 0, 6, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 0, 2'b00, 8'h00, 0, 6, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 0, 2'b00, 8'h01, 1, 6, 8));
        tbl.push_back(mkVec(0, 8'h05, 8'h00, 8'hFF, 1, 2'b01, 8'h01, 0, 5, 8));
        tbl.push_back(mkVec(0, 8'h00, 8'h00, 8'hFF, 1, 2'b01, 8'h00, 0, 6, 8));
        tbl.push_back(mkVec(0, 8'h00, 8'h00, 8'hFF, 0, 2'b01, 8'h00, 0, 7, 8));
        // Owner 3 holds the port for a 4-flit packet while requester 5 waits
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 0, 2'b00, 8'h00, 0, 8, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 0, 2'b00, 8'h08, 1, 8, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 1, 2'b00, 8'h08, 0, 7, 8));
        tbl.push_back(mkVec(0, 8'h20, 8'h00, 8'h00, 0, 2'b00, 8'h08, 0, 7, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 0, 2'b00, 8'h08, 1, 7, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 1, 2'b00, 8'h08, 0, 6, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 0, 2'b00, 8'h08, 1, 6, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h00, 1, 2'b00, 8'h08, 0, 5, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h08, 0, 2'b00, 8'h08, 1, 5, 8));
        tbl.push_back(mkVec(0, 8'h28, 8'h00, 8'h08, 1, 2'b00, 8'h08, 0, 4, 8));
        tbl.push_back(mkVec(0, 8'h20, 8'h00, 8'h20, 0, 2'b00, 8'h00, 0, 4, 8));
        tbl.push_back(mkVec(0, 8'h20, 8'h00, 8'h20, 0, 2'b00, 8'h20, 1, 4, 8));
        tbl.push_back(mkVec(0, 8'h00, 8'h00, 8'h00, 1, 2'b01, 8'h20, 0, 3, 8));
        // Reset while waiting for the link ack with three credits left on VC0
        tbl.push_back(mkVec(0, 8'h01, 8'h00, 8'h00, 0, 2'b00, 8'h00, 0, 4, 8));
        tbl.push_back(mkVec(0, 8'h01, 8'h00, 8'h00, 0, 2'b00, 8'h01, 1, 4, 8));
        tbl.push_back(mkVec(1, 8'h01, 8'h00, 8'h00, 1, 2'b00, 8'h01, 0, 3, 8));
        tbl.push_back(mkVec(0, 8'h00, 8'h00, 8'h00, 1, 2'b00, 8'h00, 0, 8, 8));
        tbl.push_back(mkVec(0, 8'h00, 8'h00, 8'h00, 0, 2'b00, 8'h00, 0, 8, 8));

        foreach (tbl[n]) begin
            applyStimulus(tbl[n].rst, tbl[n].req, tbl[n].vc, tbl[n].tail, tbl[n].flit, tbl[n].cg);
            checkOutput($sformatf("vec%0d_grant", n), 32'(grant), 32'(tbl[n].e_grant));
            checkOutput($sformatf("vec%0d_issue", n), 32'(issue), 32'(tbl[n].e_issue));
            checkOutput($sformatf("vec%0d_c0", n), 32'(credits[0]), 32'(tbl[n].e_c0));
            checkOutput($sformatf("vec%0d_c1", n), 32'(credits[1]), 32'(tbl[n].e_c1));
            if (tbl[n].e_issue) begin
                checkOutput($sformatf("vec%0d_issue_vc", n), 32'(issue_vc), 32'h0);
            end
        end

        // Requester 2 streams on VC1 until credits run dry, then resumes on one return
        applyStimulus(0, 8'h04, 8'h04, 8'h00, 0, 2'b00);
        checkOutput("vc1_idle_grant", 32'(grant), 32'h0);
        exp_c = 4'd8;
        for (int f = 0; f < 8; f++) begin
            applyStimulus(0, 8'h04, 8'h04, 8'h00, 0, 2'b00);
            checkOutput($sformatf("vc1_f%0d_grant", f), 32'(grant), 32'h04);
            checkOutput($sformatf("vc1_f%0d_issue", f), 32'(issue), 32'h1);
            checkOutput($sformatf("vc1_f%0d_issue_vc", f), 32'(issue_vc), 32'h1);
            checkOutput($sformatf("vc1_f%0d_c1", f), 32'(credits[1]), 32'(exp_c));
            exp_c = exp_c - 4'd1;
            applyStimulus(0, 8'h04, 8'h04, 8'h00, 1, 2'b00);
            checkOutput($sformatf("vc1_f%0d_ack_issue", f), 32'(issue), 32'h0);
            checkOutput($sformatf("vc1_f%0d_ack_c1", f), 32'(credits[1]), 32'(exp_c));
        end
        for (int b = 0; b < 2; b++) begin
            applyStimulus(0, 8'h04, 8'h04, 8'h04, 0, 2'b00);
            checkOutput($sformatf("vc1_blocked%0d_issue", b), 32'(issue), 32'h0);
            checkOutput($sformatf("vc1_blocked%0d_grant", b), 32'(grant), 32'h04);
        end
        applyStimulus(0, 8'h04, 8'h04, 8'h04, 0, 2'b10);
        checkOutput("vc1_return_issue", 32'(issue), 32'h0);
        checkOutput("vc1_return_c1", 32'(credits[1]), 32'h0);
        applyStimulus(0, 8'h04, 8'h04, 8'h04, 0, 2'b00);
        checkOutput("vc1_resume_issue", 32'(issue), 32'h1);
        checkOutput("vc1_resume_c1", 32'(credits[1]), 32'h1);
        applyStimulus(0, 8'h00, 8'h04, 8'h04, 1, 2'b00);
        checkOutput("vc1_tail_ack_c1", 32'(credits[1]), 32'h0);
        checkOutput("vc1_tail_ack_grant", 32'(grant), 32'h04);
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 2'b00);
        checkOutput("vc1_release_grant", 32'(grant), 32'h0);

        // Simultaneous issue and return at five credits, then a return at full count
        applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 2'b00);
        applyStimulus(0, 8'h02, 8'h00, 8'h00, 0, 2'b00);
        checkOutput("cr_post_reset_c1", 32'(credits[1]), 32'd8);
        exp_c = 4'd8;
        for (int f = 0; f < 3; f++) begin
            applyStimulus(0, 8'h02, 8'h00, 8'h00, 0, 2'b00);
            checkOutput($sformatf("cr_f%0d_c0", f), 32'(credits[0]), 32'(exp_c));
            exp_c = exp_c - 4'd1;
            applyStimulus(0, 8'h02, 8'h00, 8'h00, 1, 2'b00);
        end
        applyStimulus(0, 8'h02, 8'h00, 8'h02, 0, 2'b01);
        checkOutput("cr_same_issue", 32'(issue), 32'h1);
        checkOutput("cr_same_before", 32'(credits[0]), 32'd5);
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 1, 2'b00);
        checkOutput("cr_same_after", 32'(credits[0]), 32'd5);
        exp_c = 4'd5;
        for (int r = 0; r < 3; r++) begin
            applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 2'b01);
            checkOutput($sformatf("cr_ret%0d_c0", r), 32'(credits[0]), 32'(exp_c));
            checkOutput($sformatf("cr_ret%0d_err", r), 32'(err_credit), 32'h0);
            exp_c = exp_c + 4'd1;
        end
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 2'b01);
        checkOutput("cr_full_c0", 32'(credits[0]), 32'd8);
        checkOutput("cr_full_err_before", 32'(err_credit), 32'h0);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 2'b00);
            checkOutput($sformatf("cr_sticky%0d_err", s), 32'(err_credit), 32'h1);
            checkOutput($sformatf("cr_sticky%0d_c0", s), 32'(credits[0]), 32'd8);
        end
        applyStimulus(1, 8'h00, 8'h00, 8'h00, 0, 2'b00);
        checkOutput("cr_err_during_rst", 32'(err_credit), 32'h1);
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 2'b00);
        checkOutput("cr_err_cleared", 32'(err_credit), 32'h0);

        // Owner 0 goes silent after grant; requester 4 must get the port after the timeout
        applyStimulus(0, 8'h11, 8'h00, 8'h00, 0, 2'b00);
        checkOutput("wd_idle_grant", 32'(grant), 32'h0);
        for (int k = 1; k <= 64; k++) begin
            applyStimulus(0, 8'h10, 8'h00, 8'h00, 0, 2'b00);
            checkOutput($sformatf("wd_c%0d_grant", k), 32'(grant), 32'h01);
            checkOutput($sformatf("wd_c%0d_issue", k), 32'(issue), 32'h0);
            checkOutput($sformatf("wd_c%0d_err", k), 32'(err_timeout), (k == 64) ? 32'h1 : 32'h0);
        end
        applyStimulus(0, 8'h10, 8'h00, 8'h10, 0, 2'b00);
        checkOutput("wd_release_grant", 32'(grant), 32'h0);
        checkOutput("wd_release_err", 32'(err_timeout), 32'h0);
        applyStimulus(0, 8'h10, 8'h00, 8'h10, 0, 2'b00);
        checkOutput("wd_next_grant", 32'(grant), 32'h10);
        checkOutput("wd_next_issue", 32'(issue), 32'h1);

        // Reset while an issue is pending must suppress it
        applyStimulus(1, 8'h10, 8'h00, 8'h10, 0, 2'b00);
        checkOutput("rst_locked_issue", 32'(issue), 32'h0);
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0, 2'b00);
        checkOutput("rst_locked_grant", 32'(grant), 32'h0);
        checkOutput("rst_locked_c0", 32'(credits[0]), 32'd8);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
